// File: rtl/common_fifo_credit_pkg.sv
// Shared types and helpers for the credit-based FIFO link (transmitter side and
// the matching receiver).
package common_fifo_credit_pkg;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'b00,
      CNT_DEC  = 2'b01,
      CNT_INC  = 2'b10,
      CNT_NET  = 2'b11
   } cnt_op_e;

   function automatic int credit_width(input int max_credit);
      return $clog2(max_credit + 1);
   endfunction

endpackage

// File: rtl/common_credit_counter_sat.sv
// Up/down counter that saturates at zero and at MAX; a lone increment at
// MAX is reported on ovf_pulse instead of wrapping.
module common_credit_counter_sat
   import common_fifo_credit_pkg::*;
#(
   parameter int MAX         = 4,
   parameter int RESET_VALUE = 4,
   parameter int W           = credit_width(MAX)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero,
   output logic         at_max,
   output logic         ovf_pulse
);

   localparam logic [W-1:0] MAX_V = W'(MAX);
   localparam logic [W-1:0] RST_V = W'(RESET_VALUE);
   localparam logic [W-1:0] ONE   = W'(1);

   cnt_op_e      op;
   logic [W-1:0] cnt_nxt;

   assign op     = cnt_op_e'({inc, dec});
   assign zero   = (cnt == '0);
   assign at_max = (cnt == MAX_V);

   always_comb begin
      cnt_nxt   = cnt;
      ovf_pulse = 1'b0;
      unique case (op)
         CNT_DEC: begin
            if (!zero) cnt_nxt = cnt - ONE;
         end
         CNT_INC: begin
            if (at_max) ovf_pulse = 1'b1;
            else        cnt_nxt   = cnt + ONE;
         end
         CNT_HOLD,
         CNT_NET: cnt_nxt = cnt;
         default: cnt_nxt = cnt;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt <= RST_V;
      else        cnt <= cnt_nxt;
   end

endmodule

// File: rtl/common_fifo_credit_tx.sv
// Credit-based transmitter: pushes into a remote FIFO over a registered link
// only while it holds credit, so the far FIFO never sees a push when full.
module common_fifo_credit_tx
   import common_fifo_credit_pkg::*;
#(
   parameter  int FIFO_WIDTH   = 1,
   parameter  int CREDIT_MAX   = 4,
   localparam int CREDIT_WIDTH = credit_width(CREDIT_MAX)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [FIFO_WIDTH-1:0]   s_din,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [FIFO_WIDTH-1:0]   m_dout,
   output logic                    m_wen,
   input  logic                    m_credit_ret,
   output logic [CREDIT_WIDTH-1:0] credit_cnt,
   output logic                    credit_idle,
   output logic                    err_overflow
);

   logic zero;
   logic at_max;
   logic ovf_pulse;
   logic accept;

   // s_ready depends only on the registered count, never on inputs
   assign s_ready     = ~zero;
   assign accept      = s_valid & s_ready;
   assign credit_idle = at_max;

   common_credit_counter_sat #(
      .MAX         (CREDIT_MAX),
      .RESET_VALUE (CREDIT_MAX),
      .W           (CREDIT_WIDTH)
   ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (m_credit_ret),
      .dec       (accept),
      .cnt       (credit_cnt),
      .zero      (zero),
      .at_max    (at_max),
      .ovf_pulse (ovf_pulse)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_wen  <= 1'b0;
         m_dout <= '0;
      end else begin
         m_wen <= accept;
         if (accept) m_dout <= s_din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         err_overflow <= 1'b0;
      else if (ovf_pulse) err_overflow <= 1'b1;
   end

endmodule
